// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the PC control slice.
// Covers branch condition codes, exception cause codes and PC update FSM states.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    BR_EQ = 2'b00,
    BR_NE = 2'b01,
    BR_GT = 2'b10,
    BR_LE = 2'b11
  } br_op_e;

  typedef enum logic [1:0] {
    CAUSE_OPCODE = 2'b00,
    CAUSE_OVF    = 2'b01,
    CAUSE_DIV0   = 2'b10,
    CAUSE_ALIGN  = 2'b11
  } cause_e;

  typedef enum logic {
    ST_RUN       = 1'b0,
    ST_TRAP_WAIT = 1'b1
  } pc_state_e;

  localparam int CNT_W = 5;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch resolution from ALU flags.
// Shared with the branch-predict and debug logic.
module branch_cond_eval
  import pc_ctrl_pkg::*;
(
  input  logic [1:0] branch_op_i,
  input  logic       alu_zero_i,
  input  logic       alu_gt_i,
  output logic       cond_true_o
);

  always_comb begin
    cond_true_o = 1'b0;
    unique case (br_op_e'(branch_op_i))
      BR_EQ:   cond_true_o = alu_zero_i;
      BR_NE:   cond_true_o = ~alu_zero_i;
      BR_GT:   cond_true_o = alu_gt_i;
      BR_LE:   cond_true_o = ~alu_gt_i;
      default: cond_true_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_update_unit.sv
// PC register stage with EPC/cause capture and a trap-entry wait window.
// Define PC_ALIGN_CHECK_EN to trap on misaligned PC loads (align_fault pulses).
module pc_update_unit
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] EPC_OFFSET   = 32'd4,
  parameter int          TRAP_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_next,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic [1:0]  branch_op,
  input  logic        alu_zero,
  input  logic        alu_gt,
  input  logic        exc_req,
  input  logic [1:0]  exc_cause,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic        exc_pending,
  output logic        double_fault,
  output logic        trap_timeout,
  output logic        align_fault
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TRAP_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  pc_state_e         state_q;
  logic [31:0]       pc_q, epc_q;
  logic [1:0]        cause_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              double_fault_q, trap_timeout_q, align_fault_q;
  logic              cond_true, pc_we, misaligned;

  branch_cond_eval u_branch_cond_eval (
    .branch_op_i (branch_op),
    .alu_zero_i  (alu_zero),
    .alu_gt_i    (alu_gt),
    .cond_true_o (cond_true)
  );

  assign pc_we = pc_write | (pc_write_cond & cond_true);
  assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

`ifdef PC_ALIGN_CHECK_EN
  assign misaligned = |pc_next[1:0];
`else
  assign misaligned = 1'b0;
`endif

  // In TRAP_WAIT only an unconditional write (the handler vector) may leave the window.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_RUN;
      pc_q           <= RESET_PC;
      epc_q          <= '0;
      cause_q        <= '0;
      cnt_q          <= '0;
      double_fault_q <= 1'b0;
      trap_timeout_q <= 1'b0;
      align_fault_q  <= 1'b0;
    end else begin
      align_fault_q <= 1'b0;
      unique case (state_q)
        ST_RUN: begin
          cnt_q <= '0;
          if (exc_req) begin
            epc_q   <= pc_q - EPC_OFFSET;
            cause_q <= exc_cause;
            state_q <= ST_TRAP_WAIT;
          end else if (pc_we && misaligned) begin
            epc_q         <= pc_q;
            cause_q       <= CAUSE_ALIGN;
            align_fault_q <= 1'b1;
            state_q       <= ST_TRAP_WAIT;
          end else if (pc_we) begin
            pc_q <= pc_next;
          end
        end
        ST_TRAP_WAIT: begin
          cnt_q <= cnt_d;
          if (cnt_d >= TIMEOUT_CNT) trap_timeout_q <= 1'b1;
          if (exc_req) double_fault_q <= 1'b1;
          if (pc_write) begin
            if (misaligned) begin
              double_fault_q <= 1'b1;
            end else begin
              pc_q    <= pc_next;
              cnt_q   <= '0;
              state_q <= ST_RUN;
            end
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign pc           = pc_q;
  assign epc          = epc_q;
  assign cause        = cause_q;
  assign exc_pending  = (state_q == ST_TRAP_WAIT);
  assign double_fault = double_fault_q;
  assign trap_timeout = trap_timeout_q;
  assign align_fault  = align_fault_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed self-checking bench for pc_update_unit (branch, exception, timeout, wrap and alignment cases).
module tb_pc_update_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pcNext;
  logic        pcWrite, pcWriteCond, aluZero, aluGt, excReq;
  logic [1:0]  branchOp, excCause;
  logic [31:0] pc, epc;
  logic [1:0]  cause;
  logic        excPending, doubleFault, trapTimeout, alignFault;

  int checks   = 0;
  int failures = 0;
  logic [31:0] expPc;

  pc_update_unit dut (
    .clk           (clock),
    .reset         (reset),
    .pc_next       (pcNext),
    .pc_write      (pcWrite),
    .pc_write_cond (pcWriteCond),
    .branch_op     (branchOp),
    .alu_zero      (aluZero),
    .alu_gt        (aluGt),
    .exc_req       (excReq),
    .exc_cause     (excCause),
    .pc            (pc),
    .epc           (epc),
    .cause         (cause),
    .exc_pending   (excPending),
    .double_fault  (doubleFault),
    .trap_timeout  (trapTimeout),
    .align_fault   (alignFault)
  );

  always #5 clock = ~clock;

  // Drive one cycle of inputs, then let a rising edge pass and settle.
  task automatic applyStimulus(input logic [31:0] nxt, input logic wr, input logic wrCond,
                               input logic [1:0] op, input logic z, input logic gt,
                               input logic exc, input logic [1:0] cse);
    pcNext = nxt; pcWrite = wr; pcWriteCond = wrCond; branchOp = op;
    aluZero = z; aluGt = gt; excReq = exc; excCause = cse;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Branch vectors: {op, zero, gt, taken}
  typedef struct { logic [1:0] op; logic z; logic gt; logic taken; } brVec_t;
  brVec_t brVecs[8] = '{
    '{2'b01, 1'b1, 1'b0, 1'b0},
    '{2'b01, 1'b0, 1'b1, 1'b1},
    '{2'b00, 1'b1, 1'b0, 1'b1},
    '{2'b00, 1'b0, 1'b1, 1'b0},
    '{2'b10, 1'b0, 1'b1, 1'b1},
    '{2'b10, 1'b1, 1'b0, 1'b0},
    '{2'b11, 1'b1, 1'b0, 1'b1},
    '{2'b11, 1'b0, 1'b1, 1'b0}
  };

  initial begin
    reset = 1'b0;
    applyStimulus(32'h10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    checkOutput("reset_pc", pc, 32'h0);
    checkOutput("reset_epc", epc, 32'h0);
    checkOutput("reset_cause", {30'b0, cause}, 32'h0);
    checkOutput("reset_flags", {28'b0, excPending, doubleFault, trapTimeout, alignFault}, 32'h0);

    reset = 1'b1;
    applyStimulus(32'h10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    checkOutput("first_write", pc, 32'h10);
    expPc = 32'h10;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(32'h40 + 32'(i) * 32'h10, 1'b0, 1'b1, brVecs[i].op, brVecs[i].z,
                    brVecs[i].gt, 1'b0, 2'b00);
      if (brVecs[i].taken) expPc = 32'h40 + 32'(i) * 32'h10;
      checkOutput($sformatf("branch_%0d", i), pc, expPc);
    end

    applyStimulus(32'h500, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00);
    checkOutput("no_cond_no_load", pc, expPc);

    applyStimulus(32'h104, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    checkOutput("set_pc_104", pc, 32'h104);
    applyStimulus(32'h200, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b01);
    checkOutput("exc_pc_held", pc, 32'h104);
    checkOutput("exc_epc", epc, 32'h100);
    checkOutput("exc_cause", {30'b0, cause}, 32'h1);
    checkOutput("exc_pending", {31'b0, excPending}, 32'h1);

    applyStimulus(32'h300, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 2'b10);
    checkOutput("df_set", {31'b0, doubleFault}, 32'h1);
    checkOutput("df_epc_kept", epc, 32'h100);
    checkOutput("df_cause_kept", {30'b0, cause}, 32'h1);
    checkOutput("trap_cond_ignored", pc, 32'h104);

    idle(14);
    checkOutput("timeout_not_yet", {31'b0, trapTimeout}, 32'h0);
    idle(1);
    checkOutput("timeout_set", {31'b0, trapTimeout}, 32'h1);
    checkOutput("still_pending", {31'b0, excPending}, 32'h1);

    applyStimulus(32'h8000_0180, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    checkOutput("handler_pc", pc, 32'h8000_0180);
    checkOutput("handler_exit", {31'b0, excPending}, 32'h0);
    checkOutput("sticky_flags", {30'b0, doubleFault, trapTimeout}, 32'h3);

    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    checkOutput("sticky_cleared", {30'b0, doubleFault, trapTimeout}, 32'h0);
    applyStimulus(32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00);
    checkOutput("wrap_epc", epc, 32'hFFFF_FFFC);
    checkOutput("wrap_pending", {31'b0, excPending}, 32'h1);
    idle(2);
    reset = 1'b0;
    idle(1);
    checkOutput("midtrap_reset_pc", pc, 32'h0);
    checkOutput("midtrap_reset_epc", epc, 32'h0);
    checkOutput("midtrap_reset_flags", {26'b0, cause, excPending, doubleFault, trapTimeout, alignFault}, 32'h0);
    reset = 1'b1;

    applyStimulus(32'h20, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    checkOutput("align_setup", pc, 32'h20);
    applyStimulus(32'h22, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
`ifdef PC_ALIGN_CHECK_EN
    checkOutput("align_pc_held", pc, 32'h20);
    checkOutput("align_epc", epc, 32'h20);
    checkOutput("align_cause", {30'b0, cause}, 32'h3);
    checkOutput("align_pulse", {30'b0, alignFault, excPending}, 32'h3);
    idle(1);
    checkOutput("align_pulse_end", {31'b0, alignFault}, 32'h0);
`else
    checkOutput("noalign_pc", pc, 32'h22);
    checkOutput("noalign_flags", {30'b0, alignFault, excPending}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
